writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
Final pipeline stage; sole driver of the register file write port (WE, RD_PTR, RD).
- Accepts completed instructions from execute over a valid/ready handshake.
- For loads, performs the data-memory read, then aligns and sign/zero-extends the data.
- Presents exactly one registered write pulse per retiring instruction; the regfile samples it on the following negedge.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles o_MEM_REQ may wait for i_MEM_ACK before a bus-timeout abort (1..65535).

Ports:
- i_CLK  in  1  clock; all state updates on posedge.
- i_RSTn  in  1  asynchronous active-low reset.
- i_EX_VALID  in  1  execute holds a valid instruction.
- o_EX_READY  out  1  this stage accepts the instruction this cycle.
- i_EX_RD_WE  in  1  instruction writes rd.
- i_EX_RD_PTR  in  5  destination register index.
- i_EX_RESULT  in  32  ALU result, or effective address for loads.
- i_EX_IS_LOAD  in  1  instruction is a load.
- i_EX_FUNCT3  in  3  load width/sign code.
- o_MEM_REQ  out  1  data-memory read request.
- o_MEM_ADDR  out  32  word-aligned read address ({addr[31:2],2'b00}).
- i_MEM_ACK  in  1  read data valid this cycle.
- i_MEM_RDATA  in  32  read data word.
- o_WE  out  1  regfile write enable.
- o_RD_PTR  out  5  regfile write index.
- o_RD  out  32  regfile write data.
- o_EXC  out  1  one-cycle exception pulse.
- o_EXC_CAUSE  out  2  01 misaligned, 10 bus timeout, 11 illegal funct3; valid only while o_EXC=1.

Behaviour:
Reset:
- All outputs 0 except o_EX_READY, which is 1 (combinational from state IDLE); FSM goes to IDLE and the timeout counter clears.
- Reset asserted mid-load drops o_MEM_REQ immediately (asynchronous); the in-flight load is discarded and any later ACK is ignored.

Handshake and readiness:
- Accept occurs when i_EX_VALID && o_EX_READY.
- o_EX_READY = (state==IDLE); it is low throughout MEM_WAIT.

FSM states: IDLE, MEM_WAIT.
- IDLE, accept of a non-load: next cycle o_WE = i_EX_RD_WE && (i_EX_RD_PTR!=0), o_RD_PTR=rd, o_RD=i_EX_RESULT. Latency 1; throughput 1 per cycle.
- IDLE, accept of a load with illegal funct3 (011/110/111): next cycle o_EXC=1, cause 11, o_WE=0; stay in IDLE.
- IDLE, accept of a misaligned load (LH/LHU with addr[0]=1; LW with addr[1:0]!=0): next cycle o_EXC=1, cause 01, o_WE=0; stay in IDLE.
- IDLE, accept of any other load: latch rd, rd_we, funct3 and addr[1:0]; next cycle o_MEM_REQ=1 and o_MEM_ADDR is driven; go to MEM_WAIT.
- MEM_WAIT: o_MEM_REQ and o_MEM_ADDR held stable; the counter increments each cycle without ACK.
- MEM_WAIT, i_MEM_ACK=1: next cycle o_MEM_REQ=0, o_WE=rd_we && rd!=0, o_RD=aligned data; return to IDLE. ACK in the first REQ cycle is legal (load latency 2 from accept).
- MEM_WAIT, counter reaches TIMEOUT_CYCLES with no ACK: next cycle o_MEM_REQ=0, o_EXC=1, cause 10, no write; return to IDLE.
- ACK on the same cycle as the timeout: ACK wins.
- ACK while not in MEM_WAIT: ignored.

Write-port rules:
- o_WE, o_RD_PTR and o_RD are registered and valid for exactly one cycle per retiring instruction; o_WE=0 otherwise.
- o_RD_PTR and o_RD hold their last value when o_WE=0.
- A load to x0 still performs the memory access; the write is suppressed.

Alignment (funct3 with addr[1:0]):
- LB (000) / LBU (100): select byte at offset addr[1:0]; sign- or zero-extend to 32 bits.
- LH (001) / LHU (101): select halfword at offset addr[1]; sign- or zero-extend to 32 bits.
- LW (010): word passed through unchanged.

Decomposition:
- Shared package holds:
  - funct3 constants LB, LH, LW, LBU, LHU.
  - exception cause codes EXC_MISALIGN=2'b01, EXC_BUS_TO=2'b10, EXC_ILLEGAL=2'b11.
  - FSM state encoding.
- One combinational sub-module, load_align: inputs RDATA, funct3, addr[1:0]; output 32-bit extended data.

Test Plan:
- Reset release, then ALU accept rd=5, result 0xDEADBEEF -> next cycle o_WE=1, o_RD_PTR=5, o_RD=0xDEADBEEF; o_WE=0 the cycle after.
- Back-to-back ALU ops to rd=1 and rd=2, plus one op to rd=0 -> writes on consecutive cycles; the rd=0 op produces o_WE=0.
- Load at addr 0x103, RDATA=0x80FF1234:
  - funct3=LB -> o_MEM_ADDR=0x100, o_RD=0xFFFFFF80.
  - funct3=LBU -> o_RD=0x00000080.
- LH at 0x102 with RDATA=0x8001FFFF -> o_RD=0xFFFF8001; LW at 0x101 -> o_EXC=1, cause 01, no o_MEM_REQ, no write.
- TIMEOUT_CYCLES=4, load with ACK never asserted -> o_MEM_REQ held, then dropped; o_EXC=1, cause 10; o_EX_READY returns to 1.
- Assert i_RSTn=0 mid-MEM_WAIT, then a late ACK -> o_MEM_REQ drops asynchronously; no o_WE pulse and no o_EXC.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes, exception
// cause codes, FSM state encoding and the load legality helpers.
package writeback_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_BUS_TO   = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } wb_state_t;

  // Only the five load encodings above are legal.
  function automatic logic is_illegal_f3(input logic [2:0] f3);
    return !(f3 == F3_LB || f3 == F3_LH || f3 == F3_LW ||
             f3 == F3_LBU || f3 == F3_LHU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if ((f3 == F3_LH || f3 == F3_LHU) && off[0]) mis = 1'b1;
    if (f3 == F3_LW && off != 2'b00)             mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/writeback_unit_load_align.sv
// load_align: selects the byte/halfword/word addressed by a load out of the
// 32-bit memory word and sign- or zero-extends it.
//   rdata  : raw memory word
//   funct3 : load width/sign code
//   addr   : low two address bits (byte offset inside the word)
//   data   : extended 32-bit result (0 for non-load encodings)
module load_align
  import writeback_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    data     = '0;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'd0, half_sel};
      F3_LW:   data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage and sole driver of the regfile write
// port. ALU results retire one cycle after accept; loads issue a data-memory
// read, wait for ACK (bounded by TIMEOUT_CYCLES) and retire aligned data.
//   i_CLK, i_RSTn                    : clock, async active-low reset
//   i_EX_* / o_EX_READY              : instruction handshake from execute
//   o_MEM_REQ/o_MEM_ADDR, i_MEM_ACK/i_MEM_RDATA : data-memory read port
//   o_WE/o_RD_PTR/o_RD               : registered regfile write pulse
//   o_EXC/o_EXC_CAUSE                : one-cycle exception pulse and cause
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_CLK,
  input  logic        i_RSTn,
  input  logic        i_EX_VALID,
  output logic        o_EX_READY,
  input  logic        i_EX_RD_WE,
  input  logic [4:0]  i_EX_RD_PTR,
  input  logic [31:0] i_EX_RESULT,
  input  logic        i_EX_IS_LOAD,
  input  logic [2:0]  i_EX_FUNCT3,
  output logic        o_MEM_REQ,
  output logic [31:0] o_MEM_ADDR,
  input  logic        i_MEM_ACK,
  input  logic [31:0] i_MEM_RDATA,
  output logic        o_WE,
  output logic [4:0]  o_RD_PTR,
  output logic [31:0] o_RD,
  output logic        o_EXC,
  output logic [1:0]  o_EXC_CAUSE
);

  // Counter holds the number of REQ cycles already spent without ACK; the
  // abort fires in the TIMEOUT_CYCLES-th REQ cycle.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  wb_state_t   state;
  logic [15:0] to_cnt;
  logic [4:0]  ld_rd;
  logic        ld_we;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;
  logic [31:0] aligned;

  assign o_EX_READY = (state == ST_IDLE);

  load_align u_align (
    .rdata  (i_MEM_RDATA),
    .funct3 (ld_f3),
    .addr   (ld_off),
    .data   (aligned)
  );

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state       <= ST_IDLE;
      to_cnt      <= '0;
      ld_rd       <= '0;
      ld_we       <= 1'b0;
      ld_f3       <= '0;
      ld_off      <= '0;
      o_MEM_REQ   <= 1'b0;
      o_MEM_ADDR  <= '0;
      o_WE        <= 1'b0;
      o_RD_PTR    <= '0;
      o_RD        <= '0;
      o_EXC       <= 1'b0;
      o_EXC_CAUSE <= '0;
    end else begin
      // Pulses default low; o_RD_PTR/o_RD keep their last written value.
      o_WE        <= 1'b0;
      o_EXC       <= 1'b0;
      o_EXC_CAUSE <= '0;
      case (state)
        ST_IDLE: begin
          if (i_EX_VALID) begin
            if (!i_EX_IS_LOAD) begin
              if (i_EX_RD_WE && i_EX_RD_PTR != 5'd0) begin
                o_WE     <= 1'b1;
                o_RD_PTR <= i_EX_RD_PTR;
                o_RD     <= i_EX_RESULT;
              end
            end else if (is_illegal_f3(i_EX_FUNCT3)) begin
              o_EXC       <= 1'b1;
              o_EXC_CAUSE <= EXC_ILLEGAL;
            end else if (is_misaligned(i_EX_FUNCT3, i_EX_RESULT[1:0])) begin
              o_EXC       <= 1'b1;
              o_EXC_CAUSE <= EXC_MISALIGN;
            end else begin
              ld_rd      <= i_EX_RD_PTR;
              ld_we      <= i_EX_RD_WE;
              ld_f3      <= i_EX_FUNCT3;
              ld_off     <= i_EX_RESULT[1:0];
              o_MEM_REQ  <= 1'b1;
              o_MEM_ADDR <= {i_EX_RESULT[31:2], 2'b00};
              to_cnt     <= '0;
              state      <= ST_MEM_WAIT;
            end
          end
        end
        ST_MEM_WAIT: begin
          // ACK takes priority over a simultaneous timeout.
          if (i_MEM_ACK) begin
            o_MEM_REQ <= 1'b0;
            state     <= ST_IDLE;
            if (ld_we && ld_rd != 5'd0) begin
              o_WE     <= 1'b1;
              o_RD_PTR <= ld_rd;
              o_RD     <= aligned;
            end
          end else if (to_cnt == TO_LAST) begin
            o_MEM_REQ   <= 1'b0;
            o_EXC       <= 1'b1;
            o_EXC_CAUSE <= EXC_BUS_TO;
            state       <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: the driver predicts each observable
// retirement (write or exception) with its cycle and queues it; a negedge
// monitor pops and compares every pulse the DUT produces.
module tb_writeback_unit;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_rd_we;
  logic [4:0]  ex_rd_ptr;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        we;
  logic [4:0]  rd_ptr;
  logic [31:0] rd;
  logic        exc;
  logic [1:0]  exc_cause;

  writeback_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .i_CLK        (clk),
    .i_RSTn       (rst_n),
    .i_EX_VALID   (ex_valid),
    .o_EX_READY   (ex_ready),
    .i_EX_RD_WE   (ex_rd_we),
    .i_EX_RD_PTR  (ex_rd_ptr),
    .i_EX_RESULT  (ex_result),
    .i_EX_IS_LOAD (ex_is_load),
    .i_EX_FUNCT3  (ex_funct3),
    .o_MEM_REQ    (mem_req),
    .o_MEM_ADDR   (mem_addr),
    .i_MEM_ACK    (mem_ack),
    .i_MEM_RDATA  (mem_rdata),
    .o_WE         (we),
    .o_RD_PTR     (rd_ptr),
    .o_RD         (rd),
    .o_EXC        (exc),
    .o_EXC_CAUSE  (exc_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_exc;
    logic [4:0]  ptr;
    logic [31:0] data;
    logic [1:0]  cause;
    int          at;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: extract and extend with plain integer arithmetic.
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
    int unsigned o, b, h;
    o = int'(off);
    b = (w >> (8 * o)) & 32'd255;
    h = (w >> (16 * (o / 2))) & 32'd65535;
    case (f3)
      3'd0: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      3'd4: return 32'(b);
      3'd1: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      3'd5: return 32'(h);
      default: return w;
    endcase
  endfunction

  // 0 = ALU, 1 = illegal funct3, 2 = misaligned, 3 = legal load
  function automatic int classify(input logic ld, input logic [2:0] f3, input logic [1:0] off);
    if (!ld) return 0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1;
    if ((f3 == 3'd1 || f3 == 3'd5) && off[0]) return 2;
    if (f3 == 3'd2 && off != 2'd0) return 2;
    return 3;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (we || exc)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: we=%b exc=%b ptr=%0d rd=%h cause=%b expected none (cycle %0d)",
                 we, exc, rd_ptr, rd, exc_cause, cyc);
      end else begin
        mon_e = q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(mon_e.at));
        check("exc_flag", 32'(exc), 32'(mon_e.is_exc));
        check("we_flag", 32'(we), 32'(!mon_e.is_exc));
        if (mon_e.is_exc) begin
          check("exc_cause", 32'(exc_cause), 32'(mon_e.cause));
        end else begin
          check("rd_ptr", 32'(rd_ptr), 32'(mon_e.ptr));
          check("rd_data", rd, mon_e.data);
        end
      end
    end
  end

  task automatic push_wr(input logic [4:0] p, input logic [31:0] d, input int at);
    exp_t e;
    e.is_exc = 0; e.ptr = p; e.data = d; e.cause = 2'b00; e.at = at;
    q.push_back(e);
  endtask

  task automatic push_exc(input logic [1:0] c, input int at);
    exp_t e;
    e.is_exc = 1; e.ptr = 5'd0; e.data = 32'd0; e.cause = c; e.at = at;
    q.push_back(e);
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Presents one instruction; for legal loads also plays the memory side.
  // Non-load-issuing instructions leave ex_valid high so a following issue()
  // is accepted back-to-back; the caller ends a burst with idle().
  task automatic issue(input logic w, input logic [4:0] p, input logic [31:0] res,
                       input logic ld, input logic [2:0] f3, input logic [31:0] rdata,
                       input int d, input bit never_ack);
    int k, c, guard;
    bit acked;
    guard = 0;
    while (!ex_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ex_ready) begin
      total++; bad++;
      $display("FAIL ready_wait: got 0 expected 1 (cycle %0d)", cyc);
    end
    k = classify(ld, f3, res[1:0]);
    c = cyc;
    ex_valid = 1'b1; ex_rd_we = w; ex_rd_ptr = p; ex_result = res;
    ex_is_load = ld; ex_funct3 = f3;
    case (k)
      0: if (w && p != 5'd0) push_wr(p, res, c + 1);
      1: push_exc(2'b11, c + 1);
      2: push_exc(2'b01, c + 1);
      default: begin
        if (never_ack) push_exc(2'b10, c + 1 + TO);
        else if (w && p != 5'd0) push_wr(p, model_load(rdata, f3, res[1:0]), c + 2 + d);
      end
    endcase
    @(posedge clk); #1;
    if (k == 3) begin
      ex_valid = 1'b0;
      check("mem_req_start", 32'(mem_req), 32'd1);
      check("mem_addr", mem_addr, res & 32'hFFFF_FFFC);
      check("ready_low", 32'(ex_ready), 32'd0);
      for (int i = 0; i < TO; i++) begin
        acked = 0;
        if (!never_ack && i == d) begin
          mem_ack = 1'b1; mem_rdata = rdata; acked = 1;
        end else begin
          mem_rdata = $urandom;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (acked) break;
        if (i < TO - 1) check("mem_req_hold", 32'(mem_req), 32'd1);
      end
      check("mem_req_drop", 32'(mem_req), 32'd0);
      check("ready_back", 32'(ex_ready), 32'd1);
    end else if (k != 0) begin
      check("no_mem_req", 32'(mem_req), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        w, ld;
    logic [4:0]  p;
    logic [2:0]  f3;
    logic [31:0] res;
    rst_n = 1'b0; ex_valid = 1'b0; ex_rd_we = 1'b0; ex_rd_ptr = '0; ex_result = '0;
    ex_is_load = 1'b0; ex_funct3 = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ex_ready), 32'd1);
    check("rst_we", 32'(we), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_exc", 32'(exc), 32'd0);
    check("rst_rd", rd, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1, 5'd5, 32'hDEADBEEF, 0, 3'd0, 0, 0, 0);
    idle();
    issue(1, 5'd1, 32'h1111_0001, 0, 3'd0, 0, 0, 0);
    issue(1, 5'd2, 32'h2222_0002, 0, 3'd0, 0, 0, 0);
    issue(1, 5'd0, 32'h3333_0003, 0, 3'd0, 0, 0, 0);
    idle();
    issue(1, 5'd7,  32'h103, 1, 3'd0, 32'h80FF1234, 1, 0);
    issue(1, 5'd8,  32'h103, 1, 3'd4, 32'h80FF1234, 0, 0);
    issue(1, 5'd9,  32'h102, 1, 3'd1, 32'h8001FFFF, 2, 0);
    issue(1, 5'd10, 32'h101, 1, 3'd2, 32'h0, 0, 0);
    idle();
    issue(1, 5'd11, 32'h200, 1, 3'd2, 32'h0, 0, 1);
    issue(1, 5'd12, 32'h204, 1, 3'd2, 32'hCAFEF00D, TO - 1, 0);
    issue(1, 5'd13, 32'h300, 1, 3'd3, 32'h0, 0, 0);
    idle();
    issue(1, 5'd0, 32'h400, 1, 3'd2, 32'h12345678, 1, 0);

    for (int n = 0; n < 150; n++) begin
      w   = ($urandom % 4) != 0;
      p   = 5'($urandom);
      ld  = 1'($urandom);
      f3  = 3'($urandom);
      res = $urandom;
      issue(w, p, res, ld, f3, $urandom, int'($urandom % TO), ($urandom % 10) == 0);
      if ($urandom % 4 == 0) idle();
    end
    idle();

    // Reset in the middle of a pending load, then a stale ACK.
    ex_valid = 1'b1; ex_rd_we = 1'b1; ex_rd_ptr = 5'd3; ex_result = 32'h500;
    ex_is_load = 1'b1; ex_funct3 = 3'd2;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_req_drop", 32'(mem_req), 32'd0);
    check("async_ready", 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("late_ack_we", 32'(we), 32'd0);
    check("late_ack_exc", 32'(exc), 32'd0);
    check("late_ack_req", 32'(mem_req), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
